apb_master_fsm: RTL and testbench

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

---
 rtl/apb_master_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_apb_master_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// ---------------------------------------------------------------------------
// apb_master_fsm
//   Converts single request/response transactions into APB transfers.
//   Only one transfer is in flight at a time. The request is accepted in IDLE,
//   driven as SETUP then ACCESS on the APB, and returned as a held response.
//   If TIMEOUT_CYCLES is nonzero, a transfer whose slave never signals ready
//   is aborted after that many ACCESS cycles.
//
// Handshake semantics (request and response sides alike):
//   a beat moves on the rising edge where valid and ready are both high.
//   The producer holds valid and its payload steady until that edge. Ready
//   never depends on the payload.
//
// Ports
//   pclk_i, preset_i         clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i
//                            request payload
//   resp_valid_o/resp_ready_i response handshake
//   resp_rdata_o, resp_err_o, resp_timeout_o
//                            response payload, zero outside RESP
//   paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
//                            APB master outputs
//   pready_i, prdata_i, pslverr_i
//                            APB slave inputs, sampled only in ACCESS
//   state_o                  debug view of the FSM state
// ---------------------------------------------------------------------------
module apb_master_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    resp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i,
    output logic [1:0]              state_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                  accept;
    logic                  complete;
    logic                  expire;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  tmo_q;

    assign cnt_inc = cnt + CNT_W'(1);

    // State register
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt    = state;
        req_ready_o  = 1'b0;
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        resp_valid_o = 1'b0;
        accept       = 1'b0;
        complete     = 1'b0;
        expire       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                psel_o    = 1'b1;
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                // A ready slave wins over a counter that reaches its limit
                // in the same cycle.
                if (pready_i) begin
                    complete  = 1'b1;
                    state_nxt = S_RESP;
                end else if (TIMEOUT_EN && (cnt_inc == CNT_LIMIT)) begin
                    expire    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait-state counter: cleared on acceptance (entry to SETUP), counts
    // stalled ACCESS cycles, saturates instead of wrapping.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == S_ACCESS) && !pready_i && (cnt != CNT_MAX)) begin
            cnt <= cnt_inc;
        end
    end

    // Request and response holding registers. Read transfers carry zero
    // write data and strobes on the bus.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                write_q <= req_write_i;
                wdata_q <= req_write_i ? req_wdata_i : '0;
                strb_q  <= req_write_i ? req_strb_i : '0;
                prot_q  <= req_prot_i;
            end
            if (complete) begin
                rdata_q <= write_q ? '0 : prdata_i;
                err_q   <= pslverr_i;
                tmo_q   <= 1'b0;
            end else if (expire) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tmo_q   <= 1'b1;
            end
        end
    end

    assign paddr_o  = addr_q;
    assign pwrite_o = write_q;
    assign pwdata_o = wdata_q;
    assign pstrb_o  = strb_q;
    assign pprot_o  = prot_q;

    // Response payload is only presented while the response is valid.
    assign resp_rdata_o   = (state == S_RESP) ? rdata_q : '0;
    assign resp_err_o     = (state == S_RESP) && err_q;
    assign resp_timeout_o = (state == S_RESP) && tmo_q;

    assign state_o = state;

endmodule

// File: tb/tb_apb_master_fsm.sv
// ---------------------------------------------------------------------------
// tb_apb_master_fsm
//   Directed and randomized transactions against apb_master_fsm built with
//   TIMEOUT_CYCLES = 4. A transaction-level model predicts each response
//   and ACCESS length from the wait-state count chosen for the slave.
// ---------------------------------------------------------------------------
module tb_apb_master_fsm;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          resp_timeout;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic [1:0]    dbg_state;

  apb_master_fsm #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk_i(clk), .preset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata),
    .req_strb_i(req_strb), .req_prot_i(req_prot),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .resp_timeout_o(resp_timeout),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr),
    .state_o(dbg_state)
  );

  // scoreboard: {timeout, err, rdata}
  logic [DW+1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic garbage_slave();
    pready  = 1'($urandom);
    prdata  = $urandom;
    pslverr = 1'($urandom);
  endtask

  // driver: one complete transaction; called and returns at a negedge
  task automatic do_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int waits,
                        input logic serr, input logic [DW-1:0] rd, input int hold);
    logic [71:0]   exp_bus;
    logic [DW+1:0] exp_resp;
    logic [DW+1:0] got_resp;
    bit            tmo_hit;
    int            exp_acc;
    int            acc;
    int            lat;
    // reference model: transaction-level outcome
    tmo_hit = (waits >= TMO);
    exp_acc = tmo_hit ? TMO : waits + 1;
    exp_bus = {a, w, (w ? wd : 32'h0), (w ? st : 4'h0), pr};
    if (tmo_hit) exp_q.push_back({1'b1, 1'b1, 32'h0});
    else         exp_q.push_back({1'b0, serr, (w ? 32'h0 : rd)});

    check("idle_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
    req_strb = st; req_prot = pr;
    garbage_slave();
    @(posedge clk); lat = 1;
    @(negedge clk);
    // payload must have been captured at acceptance
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom);
    req_wdata = $urandom; req_strb = 4'($urandom); req_prot = 3'($urandom);
    garbage_slave();
    check("setup_sel_en", {psel, penable, req_ready, resp_valid}, 4'b1000);
    check("setup_bus", {paddr, pwrite, pwdata, pstrb, pprot}, exp_bus);
    @(posedge clk); lat++;
    @(negedge clk);
    acc = 0;
    while (psel === 1'b1 && penable === 1'b1 && acc < 20) begin
      acc++;
      check("access_bus", {paddr, pwrite, pwdata, pstrb, pprot}, exp_bus);
      check("access_req_ready", req_ready, 1'b0);
      pready  = (acc == waits + 1);
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? serr : 1'($urandom);
      @(posedge clk); lat++;
      @(negedge clk);
    end
    garbage_slave();
    check("access_cycles", acc, exp_acc);
    check("resp_latency", lat, 2 + exp_acc);
    check("resp_sel_en_valid", {psel, penable, resp_valid, req_ready}, 4'b0010);
    exp_resp = exp_q.pop_front();
    got_resp = {resp_timeout, resp_err, resp_rdata};
    check("resp_payload", got_resp, exp_resp);
    resp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      garbage_slave();
      check("hold_valid_ready", {resp_valid, req_ready, psel}, 3'b100);
      check("hold_payload", {resp_timeout, resp_err, resp_rdata}, exp_resp);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    garbage_slave();
    check("post_resp_idle", {resp_valid, req_ready, psel, penable}, 4'b0100);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0; req_strb = 0;
    req_prot = 0; resp_ready = 0; pready = 0; prdata = 0; pslverr = 0;

    // reset values held while reset is asserted
    @(negedge clk);
    garbage_slave();
    @(negedge clk);
    check("rst_handshake", {req_ready, psel, penable, pwrite, resp_valid, resp_err, resp_timeout},
          7'b1000000);
    check("rst_bus", {paddr, pwdata, pstrb, pprot, resp_rdata}, 80'h0);
    rst = 1'b0;
    @(negedge clk);

    // read, no wait states
    do_txn(32'h10, 1'b0, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'hCAFE0001, 0);
    // write, 3 wait states (ready arrives as counter hits its limit)
    do_txn(32'h4, 1'b1, 32'h12345678, 4'hF, 3'h2, 3, 1'b0, 32'hDEAD0000, 0);
    // slave never ready -> timeout
    do_txn(32'h20, 1'b0, 32'h0, 4'h0, 3'h1, 50, 1'b0, 32'h0, 1);
    // slave error on a read, response held for 5 cycles
    do_txn(32'h30, 1'b0, 32'hFFFF_FFFF, 4'hA, 3'h7, 1, 1'b1, 32'h5555AAAA, 5);

    // reset asserted during ACCESS
    req_valid = 1'b1; req_addr = 32'h44; req_write = 1'b1; req_wdata = 32'h99;
    req_strb = 4'h3; req_prot = 3'h5;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; pready = 1'b0;
    @(posedge clk); @(negedge clk);
    pready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_access", {psel, penable}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("async_rst_drop", {psel, penable, resp_valid, req_ready}, 4'b0001);
    check("async_rst_bus", {paddr, pwrite, pwdata, pstrb, pprot}, 72'h0);
    @(negedge clk);
    check("rst_no_resp", resp_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_resp", {resp_valid, req_ready}, 2'b01);
    do_txn(32'h50, 1'b0, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'h0BAD_F00D, 0);

    // randomized back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      do_txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
             $urandom_range(0, 6), 1'($urandom), $urandom, $urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
